// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, transmitter states and frame helpers.
// The BREAK states exist only when UART_TX_CFG_BREAK_EN is defined.
package uart_pkg;

  localparam int unsigned DATA_W_MIN = 5;
  localparam int unsigned DATA_W_MAX = 9;
  localparam int unsigned FBITS_W    = 4;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_PARITY  = 3'd3,
    ST_STOP    = 3'd4
`ifdef UART_TX_CFG_BREAK_EN
    ,
    ST_BREAK   = 3'd5,
    ST_BRK_GAP = 3'd6
`endif
  } tx_state_e;

  typedef struct packed {
    logic [1:0] parity_mode;
    logic       stop2;
  } tx_cfg_t;

  function automatic logic parity_en(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  // Bit periods in one frame: start + data + optional parity + stop bits.
  function automatic logic [FBITS_W-1:0] frame_bits(input int unsigned dw,
                                                    input logic [1:0]  mode,
                                                    input logic        stop2);
    return FBITS_W'(32'(1 + dw) + 32'(parity_en(mode)) + (stop2 ? 32'd2 : 32'd1));
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Producer-side valid/ready word handshake for the UART transmitter.
interface uart_tx_cfg_if #(parameter int unsigned DATA_W = 8);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Loadable bit-period counter: tick_c marks the last clock of each period,
// tick_next_c predicts whether the following clock is a period's last one.
module uart_baud_tick #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             tick_c,
  output logic             tick_next_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count 0..limit and restart; never runs past the limit, so no wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q >= limit_i) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign tick_c      = en_i && (cnt_q >= limit_i);
  assign tick_next_c = (cnt_d >= limit_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5..9 data bits, none/even/odd parity, 1 or 2 stop bits.
// Optional line break generation is enabled with UART_TX_CFG_BREAK_EN.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_cfg_if.slave      in_if,
  input  logic [CNT_W-1:0]  period,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
`ifdef UART_TX_CFG_BREAK_EN
  input  logic              send_break,
`endif
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BIT_W = $clog2(DATA_W);

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
    $error("uart_tx_cfg: DATA_W out of range");
  end

  tx_state_e         state_q, state_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              stop_q, stop_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  per_m1_q, per_m1_d, per_m1_in;
  tx_cfg_t           cfg_q, cfg_d;
  logic              tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic              load, bt_en, tick, tick_next;
`ifdef UART_TX_CFG_BREAK_EN
  logic [FBITS_W-1:0] brk_q, brk_d, brk_len;
  logic               brk_full;
`endif

  assign per_m1_in = (period == '0) ? '0 : period - CNT_W'(1);
  assign bt_en     = (state_q != ST_IDLE);

  uart_baud_tick #(.CNT_W(CNT_W)) u_baud (
    .clk         (clk),
    .rst_n       (rst),
    .load_i      (load),
    .en_i        (bt_en),
    .limit_i     (per_m1_q),
    .tick_c      (tick),
    .tick_next_c (tick_next)
  );

`ifdef UART_TX_CFG_BREAK_EN
  assign brk_len  = frame_bits(DATA_W, cfg_q.parity_mode, cfg_q.stop2);
  assign brk_full = (brk_q == brk_len) || (tick && (brk_q == brk_len - FBITS_W'(1)));
`endif

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    data_d   = data_q;
    per_m1_d = per_m1_q;
    cfg_d    = cfg_q;
    load     = 1'b0;
`ifdef UART_TX_CFG_BREAK_EN
    brk_d    = brk_q;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef UART_TX_CFG_BREAK_EN
        if (send_break) begin
          state_d  = ST_BREAK;
          load     = 1'b1;
          brk_d    = '0;
          per_m1_d = per_m1_in;
          cfg_d    = '{parity_mode: parity_mode, stop2: stop2};
        end else
`endif
        if (in_if.in_valid) begin
          state_d  = ST_START;
          load     = 1'b1;
          data_d   = in_if.in_data;
          per_m1_d = per_m1_in;
          cfg_d    = '{parity_mode: parity_mode, stop2: stop2};
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            state_d = parity_en(cfg_q.parity_mode) ? ST_PARITY : ST_STOP;
            stop_d  = 1'b0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          stop_d  = 1'b0;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stop_q == cfg_q.stop2) begin
            state_d = ST_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
`ifdef UART_TX_CFG_BREAK_EN
      ST_BREAK: begin
        if (tick && brk_q != brk_len) begin
          brk_d = brk_q + FBITS_W'(1);
        end
        if (brk_full && !send_break) begin
          state_d = ST_BRK_GAP;
          load    = 1'b1;
        end
      end
      ST_BRK_GAP: begin
        if (tick) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so tx tracks state with no skew.
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = data_d[bit_d];
      ST_PARITY: tx_d = (^data_d) ^ (cfg_d.parity_mode == PAR_ODD);
`ifdef UART_TX_CFG_BREAK_EN
      ST_BREAK:  tx_d = 1'b0;
`endif
      default:   tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_STOP) && (stop_d == cfg_d.stop2) && tick_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      data_q   <= '0;
      per_m1_q <= '0;
      cfg_q    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_CFG_BREAK_EN
      brk_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      data_q   <= data_d;
      per_m1_q <= per_m1_d;
      cfg_q    <= cfg_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TX_CFG_BREAK_EN
      brk_q    <= brk_d;
`endif
    end
  end

  assign in_if.in_ready = (state_q == ST_IDLE);
  assign tx             = tx_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: an 8-bit instance for framing/parity/stop/reset
// cases and a 5-bit instance for the narrow-word, zero-period case.
module tb_uart_tx_cfg;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] period, period5;
  logic [1:0]  parity_mode, parity_mode5;
  logic        stop2, stop2_5;
  logic        tx, busy, done;
  logic        tx5, busy5, done5;
  int          n_checks = 0;
  int          n_errors = 0;

  uart_tx_cfg_if #(.DATA_W(8)) bus8 ();
  uart_tx_cfg_if #(.DATA_W(5)) bus5 ();

  uart_tx_cfg #(.DATA_W(8), .CNT_W(32)) dut8 (
    .clk         (clk),
    .rst         (rst),
    .in_if       (bus8),
    .period      (period),
    .parity_mode (parity_mode),
    .stop2       (stop2),
`ifdef UART_TX_CFG_BREAK_EN
    .send_break  (1'b0),
`endif
    .tx          (tx),
    .busy        (busy),
    .done        (done)
  );

  uart_tx_cfg #(.DATA_W(5), .CNT_W(32)) dut5 (
    .clk         (clk),
    .rst         (rst),
    .in_if       (bus5),
    .period      (period5),
    .parity_mode (parity_mode5),
    .stop2       (stop2_5),
`ifdef UART_TX_CFG_BREAK_EN
    .send_break  (1'b0),
`endif
    .tx          (tx5),
    .busy        (busy5),
    .done        (done5)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // exp lists the line level of each bit period in send order (start first).
  task automatic run_frame(input string tag, input string exp, input logic [31:0] per,
                           input logic [7:0] d, input logic [1:0] pm, input logic s2,
                           input bit keep_valid, input bit scramble);
    int   p;
    int   n;
    logic b;
    p = (per == 0) ? 1 : int'(per);
    n = exp.len() * p;
    bus8.in_data = d;
    period       = per;
    parity_mode  = pm;
    stop2        = s2;
    bus8.in_valid = 1'b1;
    chk({tag, "_ready_pre"}, bus8.in_ready, 1);
    step();
    if (!keep_valid) bus8.in_valid = 1'b0;
    if (scramble) begin
      bus8.in_data = ~d;
      period       = per + 32'd5;
      parity_mode  = pm ^ 2'b11;
      stop2        = ~s2;
    end
    chk({tag, "_ready_busy"}, bus8.in_ready, 0);
    for (int k = 0; k < n; k++) begin
      b = (exp[k / p] == "1");
      chk($sformatf("%s_tx%0d", tag, k), tx, b);
      chk($sformatf("%s_done%0d", tag, k), done, (k == n - 1));
      chk($sformatf("%s_busy%0d", tag, k), busy, 1);
      step();
    end
    chk({tag, "_idle_tx"}, tx, 1);
    chk({tag, "_idle_ready"}, bus8.in_ready, 1);
    chk({tag, "_idle_done"}, done, 0);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    rst           = 1'b0;
    bus8.in_valid = 1'b0;
    bus8.in_data  = '0;
    bus5.in_valid = 1'b0;
    bus5.in_data  = '0;
    period        = 32'd4;
    parity_mode   = PAR_NONE;
    stop2         = 1'b0;
    period5       = 32'd0;
    parity_mode5  = PAR_NONE;
    stop2_5       = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", bus8.in_ready, 1);
    chk("rst_tx5", tx5, 1);
    rst = 1'b1;
    step();

    // 8N1, period 4: 0xA5 -> start, 1,0,1,0,0,1,0,1, stop
    run_frame("a5_8n1", "0101001011", 32'd4, 8'hA5, PAR_NONE, 1'b0, 1'b0, 1'b0);

    // 0x07 has three ones: even parity bit 1, odd parity bit 0
    run_frame("par_even", "01110000011", 32'd2, 8'h07, PAR_EVEN, 1'b0, 1'b0, 1'b0);
    run_frame("par_odd",  "01110000001", 32'd2, 8'h07, PAR_ODD,  1'b0, 1'b0, 1'b0);

    // Back-to-back with in_valid held, period 1, two stop bits
    run_frame("b2b_0", "00011110011", 32'd1, 8'h3C, PAR_NONE, 1'b1, 1'b1, 1'b0);
    run_frame("b2b_1", "01000000111", 32'd1, 8'h81, PAR_NONE, 1'b1, 1'b1, 1'b0);
    run_frame("b2b_2", "01111111111", 32'd1, 8'hFF, PAR_NONE, 1'b1, 1'b0, 1'b0);

    // Inputs changed mid-frame are ignored; the next frame uses new ones
    run_frame("mid_chg", "00101101001", 32'd3, 8'h5A, PAR_EVEN, 1'b0, 1'b0, 1'b1);
    run_frame("after_chg", "010000000011", 32'd2, 8'h01, PAR_ODD, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of DATA
    bus8.in_data  = 8'h00;
    period        = 32'd4;
    parity_mode   = PAR_NONE;
    stop2         = 1'b0;
    bus8.in_valid = 1'b1;
    step();
    bus8.in_valid = 1'b0;
    repeat (9) step();
    chk("midrst_pre_tx", tx, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_tx_async", tx, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ready", bus8.in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("midrst_hold_done%0d", i), done, 0);
      chk($sformatf("midrst_hold_tx%0d", i), tx, 1);
    end
    rst = 1'b1;
    step();
    run_frame("post_rst", "0101001011", 32'd1, 8'hA5, PAR_NONE, 1'b0, 1'b0, 1'b0);

    // 5-bit instance, period 0 acts as 1: 0x1F -> 7-clock frame
    bus5.in_data  = 5'h1F;
    period5       = 32'd0;
    bus5.in_valid = 1'b1;
    chk("w5_ready_pre", bus5.in_ready, 1);
    step();
    bus5.in_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("w5_tx%0d", k), tx5, (k != 0));
      chk($sformatf("w5_done%0d", k), done5, (k == 6));
      step();
    end
    chk("w5_idle_tx", tx5, 1);
    chk("w5_idle_ready", bus5.in_ready, 1);
    chk("w5_idle_busy", busy5, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised, configurable UART transmitter, the successor to the fixed 8N1 transmitter. It supports 5–9 data bits, a runtime parity mode (none/even/odd) and 1 or 2 stop bits. It has a valid/ready input handshake, a registered serial output, and busy/done status. It sits between a byte producer (FIFO or CPU register) and the board TX pin. The bit period is supplied at runtime in clock cycles.

Parameters:
DATA_W, 8, number of data bits per frame; legal 5..9
CNT_W, 32, width of period input and internal bit-period counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
period  input  CNT_W  clocks per bit; sampled at frame accept; value 0 treated as 1
parity_mode  input  2  00 none, 01 even, 10 odd, 11 none; sampled at frame accept
stop2  input  1  1 = two stop bits, 0 = one; sampled at frame accept
in_valid  input  1  producer has a word on in_data
in_ready  output  1  transmitter can accept a word (IDLE only)
in_data  input  DATA_W  word to send, LSB first
tx  output  1  serial line, idle high, registered
busy  output  1  high from cycle after accept through last stop-bit clock
done  output  1  one-cycle pulse on the final clock of the last stop bit

Behaviour:
- Reset (rst low, async): state IDLE, tx=1, busy=0, done=0, in_ready=1, all counters 0.
- Accept: the word is accepted in a cycle where in_valid=1 and in_ready=1. On accept, in_data, period, parity_mode and stop2 are latched into a shadow register. Input changes mid-frame have no effect.
- Frame states: IDLE -> START -> DATA -> PARITY (only if the latched mode is even/odd) -> STOP -> IDLE.
- Latency: tx goes low on the clock edge following accept (1-cycle latency).
- Bit timing: each bit holds tx for exactly max(period,1) clocks.
- Bit counter: counts 0..DATA_W-1 in DATA. Data bits are sent LSB first.
- STOP length: 1 or 2 bit periods per the latched stop2.
- Parity bit: even = XOR of all DATA_W bits; odd = inverted XOR.
- Frame length: 1 + DATA_W + P + S bit periods, where P is 0 or 1 and S is 1 or 2.
- Completion: done=1 on the last clock of STOP. The next cycle is IDLE with in_ready=1, so back-to-back frames are separated by exactly 1 idle-high clock.
- in_ready is combinational from state (IDLE) only. It does not depend on in_valid.
- in_valid held high continuously yields a new frame every frame_length + 1 clocks.
- Counter wrap: the period counter compares against latched period-1 (at least 0) and never wraps past it. A period of 2^CNT_W-1 is legal.
- Illegal/unused state encodings return to IDLE with tx=1 on the next clock.
- Reset asserted mid-frame aborts immediately: tx=1 asynchronously, and no done pulse is produced.

Optional Feature:
Macro UART_TX_CFG_BREAK_EN.
- Defined: adds input port send_break (1 bit) and state BREAK. In IDLE, send_break=1 takes priority over in_valid and enters BREAK. tx is held 0 while send_break stays high, with a minimum of (1+DATA_W+P+S) bit periods using the current period/config. On exit the block returns to IDLE with tx=1 for at least one bit period before in_ready reasserts. Neither busy nor done is affected except that busy=1 during BREAK.
- Not defined: no send_break port and no BREAK state; behaviour is exactly as above.

Decomposition:
- Shared package uart_pkg contains:
  - parity_mode encoding constants (PAR_NONE=2'b00, PAR_EVEN=2'b01, PAR_ODD=2'b10)
  - tx state encoding localparams/typedef
  - helper constant for max DATA_W (9)
- Sub-module uart_baud_tick: a loadable period counter with enable and a one-cycle tick output. It is reused by the future receiver.

Test Plan:
- Reset released, DATA_W=8, period=4, parity none, stop2=0, send 8'hA5 -> tx low at accept+1. Bits 1,0,1,0,0,1,0,1, each 4 clocks. Stop high 4 clocks. done at clock 40 after accept. in_ready at 41.
- parity even, data 8'h07 -> parity bit 1. parity odd, same data -> 0. Frame is 11 bit periods.
- stop2=1, period=1, back-to-back 3 words with in_valid held -> frames of 11 clocks each, separated by exactly 1 high clock, 3 done pulses.
- Change period/parity_mode/in_data mid-frame -> the current frame is unaffected and the next frame uses the new values.
- rst pulled low mid-DATA -> tx=1 same cycle (async), no done. After release, in_ready=1 and the next frame is correct.
- period=0 -> behaves as period=1. DATA_W=5 build with data 5'h1F -> 5 high data bits, frame of 7 clocks.
